// File: rtl/snake_pkg.sv
// Shared types and field layout for the snake game logic and its renderer.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    localparam int POS_W = 13;
    localparam int X_MSB = 6;
    localparam int Y_LSB = 7;
    localparam int Y_MSB = 12;
    localparam int X_W   = X_MSB + 1;
    localparam int Y_W   = Y_MSB - Y_LSB + 1;

    localparam int DEFAULT_GRID_W = 64;
    localparam int DEFAULT_GRID_H = 48;

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    // Start layout: a horizontal snake on row 0 with the head furthest right.
    function automatic logic [POS_W-1:0] init_seg(input int segments, input int idx);
        logic [X_W-1:0] x;
        x = X_W'(segments - 1 - idx);
        return {{Y_W{1'b0}}, x};
    endfunction

endpackage

// File: rtl/snake_dir_ctrl.sv
// Arrow-key decode, reversal filter and the pending/current direction registers.
module snake_dir_ctrl
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       reinit,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       move,
    output dir_t       pend_dir,
    output logic       restart
);

    dir_t r_pendDir;
    dir_t r_curDir;
    dir_t w_keyDir;
    logic w_isArrow;
    logic w_accept;

    // Map a make code to a direction; anything that is not an arrow is flagged.
    always_comb begin
        w_isArrow = 1'b1;
        w_keyDir  = DIR_RIGHT;
        case (key_code)
            KEY_RIGHT: w_keyDir = DIR_RIGHT;
            KEY_LEFT:  w_keyDir = DIR_LEFT;
            KEY_DOWN:  w_keyDir = DIR_DOWN;
            KEY_UP:    w_keyDir = DIR_UP;
            default:   w_isArrow = 1'b0;
        endcase
    end

    // A reversal is judged against the direction last moved, not the pending one.
    assign w_accept = enable && key_valid && w_isArrow && (w_keyDir != reverse_dir(r_curDir));

    // Pending direction follows accepted keys; current direction commits on each move.
    always_ff @(posedge clk) begin
        if (reset || reinit) begin
            r_pendDir <= DIR_RIGHT;
            r_curDir  <= DIR_RIGHT;
        end else begin
            if (move) begin
                r_curDir <= r_pendDir;
            end
            if (w_accept) begin
                r_pendDir <= w_keyDir;
            end
        end
    end

    assign pend_dir = r_pendDir;
    assign restart  = key_valid && (key_code == KEY_SPACE);

endmodule

// File: rtl/snake_mover.sv
// Snake game stage: step timing, run/dead FSM, segment shift register and collisions.
module snake_mover
    import snake_pkg::*;
#(
    parameter int SEGMENTS = 4,
    parameter int GRID_W   = DEFAULT_GRID_W,
    parameter int GRID_H   = DEFAULT_GRID_H,
    parameter int STEP_DIV = 4
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      key_valid,
    input  logic [7:0]                key_code,
    input  logic                      pause,
    output logic [POS_W*SEGMENTS-1:0] positions,
    output logic                      died,
    output logic                      alive
);

    localparam logic [X_W-1:0] X_MAX     = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX     = Y_W'(GRID_H - 1);
    localparam logic [3:0]     STEP_LAST = 4'(STEP_DIV - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_stepCnt;
    logic [POS_W-1:0] r_seg [SEGMENTS];
    logic             r_died;
    logic             r_alive;

    dir_t             w_pendDir;
    logic             w_restart;
    logic             w_running;
    logic             w_tickRun;
    logic             w_move;
    logic             w_reinit;
    logic [X_W-1:0]   w_headX;
    logic [Y_W-1:0]   w_headY;
    logic [X_W-1:0]   w_nextX;
    logic [Y_W-1:0]   w_nextY;
    logic [POS_W-1:0] w_nextHead;
    logic             w_wallHit;
    logic             w_selfHit;
    logic             w_collide;
    logic             w_diedNext;
    logic             w_aliveNext;

    assign w_running = (r_state == ST_RUN);
    assign w_tickRun = tick && w_running && !pause;
    assign w_move    = w_tickRun && (r_stepCnt == STEP_LAST);
    assign w_reinit  = (r_state == ST_DEAD) && w_restart;

    snake_dir_ctrl u_dirCtrl (
        .clk       (clk),
        .reset     (reset),
        .reinit    (w_reinit),
        .enable    (w_running),
        .key_valid (key_valid),
        .key_code  (key_code),
        .move      (w_move),
        .pend_dir  (w_pendDir),
        .restart   (w_restart)
    );

    assign w_headX    = r_seg[0][X_MSB:0];
    assign w_headY    = r_seg[0][Y_MSB:Y_LSB];
    assign w_nextHead = {w_nextY, w_nextX};

    // Candidate head cell one step along the pending direction, plus the wall test.
    always_comb begin
        w_nextX   = w_headX;
        w_nextY   = w_headY;
        w_wallHit = 1'b0;
        case (w_pendDir)
            DIR_RIGHT: begin
                w_nextX   = w_headX + 7'd1;
                w_wallHit = (w_headX == X_MAX);
            end
            DIR_LEFT: begin
                w_nextX   = w_headX - 7'd1;
                w_wallHit = (w_headX == '0);
            end
            DIR_DOWN: begin
                w_nextY   = w_headY + 6'd1;
                w_wallHit = (w_headY == Y_MAX);
            end
            default: begin
                w_nextY   = w_headY - 6'd1;
                w_wallHit = (w_headY == '0);
            end
        endcase
    end

    // Body hit test; the tail is skipped because it moves out of the way this step.
    always_comb begin
        w_selfHit = 1'b0;
        for (int i = 0; i < SEGMENTS - 1; i++) begin
            if (r_seg[i] == w_nextHead) begin
                w_selfHit = 1'b1;
            end
        end
    end

    assign w_collide = w_wallHit || w_selfHit;

    // Frame-tick divider; holds while paused or dead.
    always_ff @(posedge clk) begin
        if (reset || w_reinit) begin
            r_stepCnt <= '0;
        end else if (w_tickRun) begin
            r_stepCnt <= (r_stepCnt == STEP_LAST) ? 4'd0 : r_stepCnt + 4'd1;
        end
    end

    // Segment shift register: advance on a clean move, otherwise stay frozen.
    always_ff @(posedge clk) begin
        if (reset || w_reinit) begin
            for (int i = 0; i < SEGMENTS; i++) begin
                r_seg[i] <= init_seg(SEGMENTS, i);
            end
        end else if (w_move && !w_collide) begin
            r_seg[0] <= w_nextHead;
            for (int i = 1; i < SEGMENTS; i++) begin
                r_seg[i] <= r_seg[i-1];
            end
        end
    end

    // FSM state register, also registering the decoded outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_died  <= 1'b0;
            r_alive <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_died  <= w_diedNext;
            r_alive <= w_aliveNext;
        end
    end

    // FSM next state: a colliding move kills, a space key in DEAD revives.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_move && w_collide) begin
                    w_nextState = ST_DEAD;
                end
            end
            default: begin
                if (w_restart) begin
                    w_nextState = ST_RUN;
                end
            end
        endcase
    end

    // FSM outputs, computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        w_diedNext  = w_running && w_move && w_collide;
        w_aliveNext = (w_nextState == ST_RUN);
    end

    for (genvar g = 0; g < SEGMENTS; g++) begin : g_pack
        assign positions[POS_W*g +: POS_W] = r_seg[g];
    end

    assign died  = r_died;
    assign alive = r_alive;

endmodule

// File: doc/snake_mover.md
# snake_mover

Game-logic stage directly upstream of the snake renderer. It owns the segment position registers, turns PS/2 arrow-key codes into a movement direction, and advances the snake one grid cell every `STEP_DIV` frame ticks. It detects wall and self collisions, freezes on death and restarts on the space key. Its packed `positions` bus is consumed unchanged by the renderer's pixel compare.

## Interface
Parameters:
- `SEGMENTS`, 4: number of snake segments, 2..16; segment 0 is the head.
- `GRID_W`, 64: visible columns; legal x is 0..GRID_W-1.
- `GRID_H`, 48: visible rows; legal y is 0..GRID_H-1.
- `STEP_DIV`, 4: frame ticks per move, 1..15.

Ports:
- `clk`  in  1  system clock (clk25 domain). One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle pulse per frame (Vsync falling-edge detect, already in `clk` domain).
- `key_valid`  in  1  one-cycle pulse: `key_code` holds a newly pressed key (synchronized upstream).
- `key_code`  in  8  PS/2 set-2 make code.
- `pause`  in  1  level; while high, moves are suppressed and the step counter holds.
- `positions`  out  13*SEGMENTS  segment i occupies bits [13i+12:13i]; x is bits [6:0], y is bits [12:7].
- `died`  out  1  one-cycle pulse on the cycle the snake enters DEAD.
- `alive`  out  1  high in RUN, low in DEAD.

## Operation
- Direction encoding: RIGHT=0, LEFT=1, DOWN=2, UP=3. Key codes: 0x74 RIGHT, 0x6B LEFT, 0x72 DOWN, 0x75 UP, 0x29 SPACE (restart). All other codes are ignored.
- `pend_dir` register: on `key_valid` with an arrow code, it loads that direction. It does not load if the code is the exact reverse of `cur_dir` (the last direction actually moved); a reversal is silently dropped.
- Step counter, 4 bits: counts `tick` pulses while RUN and `!pause`. At `STEP_DIV-1` it wraps to 0 and issues a move on that cycle.
- Move:
  - `cur_dir <= pend_dir`.
  - Next head position = head ± 1 in x or y per `pend_dir`.
  - Wall check: RIGHT at x=GRID_W-1, LEFT at x=0, DOWN at y=GRID_H-1 and UP at y=0 are each a collision.
  - Self check: next head equals any of segments 0..SEGMENTS-2. The tail vacates its cell, so it is excluded.
  - No collision: segment i <= segment i-1 for i≥1, and segment 0 <= next head.
  - Collision: positions are unchanged, `died`=1 for one cycle, state goes to DEAD.
- FSM:
  - RUN: moves per the rules above.
  - DEAD: positions frozen; `tick`, `pause` and arrow keys are ignored. `key_valid` with 0x29 re-initializes the snake (same values as reset) and returns to RUN.
- Reset / re-init values:
  - segment i = (x=SEGMENTS-1-i, y=0).
  - `cur_dir` = `pend_dir` = RIGHT.
  - step counter = 0, state RUN, `died`=0, `alive`=1.
- Coordinates never leave the legal range, because a collision blocks the move.

## Timing
- All outputs are registered. `positions` changes on the clock edge after the cycle where `tick` causes the step counter to wrap; latency is 1 cycle from `tick`. `died` asserts on that same edge.
- `key_valid` and a move in the same cycle: the move uses `pend_dir` as it stood before the edge. The new key is captured and takes effect on the next move. The reversal check for that key compares against the pre-move `cur_dir`.
- Two keys between moves: the last accepted key wins.
- `pause` rising mid-count: the counter holds its value. Moves resume when `pause` falls, with no lost or extra ticks.
- `reset` has priority over every other input in the same cycle, including a move or a restart key.
- Restart with 0x29 while in RUN has no effect.

## Structure
- Package `snake_pkg`:
  - direction enum
  - key-code constants
  - `POS_W`=13, `X_MSB`=6, `Y_LSB`=7, `Y_MSB`=12
  - default `GRID_W`/`GRID_H`
- The renderer imports `snake_pkg` for the same field ranges.
- Sub-module `snake_dir_ctrl`: key decode, reversal filter and `pend_dir`/`cur_dir` registers. Inputs: `key_valid`, `key_code`, `move`. Outputs: `pend_dir`, `restart`.
- The top holds the step counter, FSM, position shift register and collision comparators.

## Test plan
- Reset with defaults, then 4 ticks → `positions` = {(3,0),(2,0),(1,0),(0,0)} before the 4th tick's edge; after it, head is (4,0) and the tail is (1,0).
- Press 0x72, then 4 ticks → head is (4,1) and segment 1 is (4,0). Then press 0x75 (reversal of DOWN) → it is dropped, and the next move gives head (4,2).
- Drive RIGHT until head x=63, then one more move → `died` pulses exactly 1 cycle, `alive`=0, positions unchanged. Further ticks and arrows → no change. 0x29 → reset layout, `alive`=1.
- With `SEGMENTS`=5, steer DOWN, LEFT, UP into segment 3 → death. Also a move onto the current tail cell → no death.
- `pause` high for 10 ticks mid-count at counter=2 → no moves; after release, exactly 2 more ticks are needed for the move.
- `key_valid`=0x72 coincident with the move-triggering tick while moving RIGHT → that move goes right; the following move goes down.
